// File: rtl/axis_cmult_arb.sv
// Round-robin, packet-granular arbiter feeding one shared complex multiplier from NUM_CH AXI-stream sources.
// Optional macro AXIS_CMULT_ARB_TRUNC_EN: force end-of-packet after MAX_BEATS beats and pulse err_trunc.
module axis_cmult_arb #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CH-1:0]              s_axis_tvalid,
  output logic [NUM_CH-1:0]              s_axis_tready,
  input  logic [NUM_CH-1:0]              s_axis_tlast,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   coef,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [DATA_WIDTH-1:0]          m_axis_coef,
  output logic [$clog2(NUM_CH)-1:0]      m_axis_tid,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [NUM_CH-1:0]              grant,
  output logic                           err_trunc
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || MAX_BEATS < 2) begin : g_param_check
    $error("axis_cmult_arb: unsupported parameter values");
  end

  typedef enum logic {IDLE, PASS} state_t;

  typedef struct packed {
    logic                  last;
    logic [CH_W-1:0]       tid;
    logic [DATA_WIDTH-1:0] coef;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                state_q, state_n;
  logic [CH_W-1:0]       ptr_q, ptr_n;
  logic [CH_W-1:0]       tid_q, tid_n;
  logic [NUM_CH-1:0]     grant_q, grant_n;
  logic [NUM_CH-1:0]     tready_q, tready_n;
  logic [DATA_WIDTH-1:0] coef_q, coef_n;
  beat_t                 out_q, out_n, sk_q, sk_n;
  logic                  out_vld_q, out_vld_n, sk_vld_q, sk_vld_n;
  logic                  err_q, err_n;

  logic                  accept_c;
  logic                  trunc_hit_c;
  logic                  pop_c;
  beat_t                 in_beat_c;
  logic                  found_c;
  logic [CH_W-1:0]       win_c;

`ifdef AXIS_CMULT_ARB_TRUNC_EN
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;

  // Beat MAX_BEATS of a packet without its own tlast is forced to end the packet
  assign trunc_hit_c = (cnt_q == CNT_W'(MAX_BEATS - 1)) && !s_axis_tlast[tid_q];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_n;
  end
`else
  assign trunc_hit_c = 1'b0;
`endif

  assign accept_c  = (state_q == PASS) && s_axis_tvalid[tid_q] && tready_q[tid_q];
  assign pop_c     = out_vld_q && m_axis_tready;
  assign in_beat_c = '{last: s_axis_tlast[tid_q] | trunc_hit_c,
                       tid:  tid_q,
                       coef: coef_q,
                       data: s_axis_tdata[tid_q*DATA_WIDTH +: DATA_WIDTH]};

  // Round-robin search starting at ptr
  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] idx_w;
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx   = (32'(ptr_q) + i) % NUM_CH;
      idx_w = CH_W'(idx);
      if (!found_c && s_axis_tvalid[idx_w]) begin
        found_c = 1'b1;
        win_c   = idx_w;
      end
    end
  end

  // Two-entry skid: output register plus one spill register
  always_comb begin
    out_n     = out_q;
    out_vld_n = out_vld_q;
    sk_n      = sk_q;
    sk_vld_n  = sk_vld_q;
    if (!out_vld_q || pop_c) begin
      if (sk_vld_q) begin
        out_n     = sk_q;
        out_vld_n = 1'b1;
        sk_vld_n  = accept_c;
        if (accept_c) sk_n = in_beat_c;
      end else begin
        out_vld_n = accept_c;
        if (accept_c) out_n = in_beat_c;
      end
    end else if (accept_c) begin
      sk_vld_n = 1'b1;
      sk_n     = in_beat_c;
    end
  end

  // Next-state and registered-output logic; tready only offered while the spill slot is free
  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    tid_n    = tid_q;
    grant_n  = grant_q;
    coef_n   = coef_q;
    tready_n = '0;
    err_n    = 1'b0;
`ifdef AXIS_CMULT_ARB_TRUNC_EN
    cnt_n    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_n = PASS;
          tid_n   = win_c;
          grant_n = NUM_CH'(1) << win_c;
          coef_n  = coef[win_c*DATA_WIDTH +: DATA_WIDTH];
          if (!sk_vld_n) tready_n = NUM_CH'(1) << win_c;
`ifdef AXIS_CMULT_ARB_TRUNC_EN
          cnt_n   = '0;
`endif
        end
      end
      PASS: begin
        if (accept_c && in_beat_c.last) begin
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = (tid_q == CH_W'(NUM_CH - 1)) ? '0 : tid_q + 1'b1;
          err_n   = trunc_hit_c;
        end else begin
          if (!sk_vld_n) tready_n = grant_q;
`ifdef AXIS_CMULT_ARB_TRUNC_EN
          if (accept_c) cnt_n = cnt_q + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      tid_q     <= '0;
      grant_q   <= '0;
      tready_q  <= '0;
      coef_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sk_q      <= '0;
      sk_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      tid_q     <= tid_n;
      grant_q   <= grant_n;
      tready_q  <= tready_n;
      coef_q    <= coef_n;
      out_q     <= out_n;
      out_vld_q <= out_vld_n;
      sk_q      <= sk_n;
      sk_vld_q  <= sk_vld_n;
      err_q     <= err_n;
    end
  end

  assign s_axis_tready = tready_q;
  assign grant         = grant_q;
  assign err_trunc     = err_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_coef   = out_q.coef;
  assign m_axis_tid    = out_q.tid;
  assign m_axis_tlast  = out_q.last;

endmodule
